// File: rtl/cpu_seq_m.sv
// 8-phase instruction sequencer for the 8-bit accumulator CPU.
// Ports: clk/rst (sync, active-high), opcode/zero/go in; memory, IR, PC,
// AC and bus strobes, halt, phase and retired-instruction count out.
module cpu_seq_m #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           opcode,
  input  logic                 zero,
  input  logic                 go,
  output logic                 sel,
  output logic                 mem_rd,
  output logic                 load_ir,
  output logic                 inc_pc,
  output logic                 load_pc,
  output logic                 load_ac,
  output logic                 mem_wr,
  output logic                 data_e,
  output logic                 halt,
  output logic [2:0]           phase,
  output logic [CNT_WIDTH-1:0] instr_cnt
);

  typedef enum logic {
    RUN,
    HALTED
  } state_e;

  localparam logic [2:0] P_INST_ADDR  = 3'd0;
  localparam logic [2:0] P_INST_FETCH = 3'd1;
  localparam logic [2:0] P_INST_LOAD  = 3'd2;
  localparam logic [2:0] P_IDLE       = 3'd3;
  localparam logic [2:0] P_OP_ADDR    = 3'd4;
  localparam logic [2:0] P_OP_FETCH   = 3'd5;
  localparam logic [2:0] P_ALU_OP     = 3'd6;
  localparam logic [2:0] P_STORE      = 3'd7;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  state_e               state_q, state_d;
  logic [2:0]           phase_q, phase_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic is_hlt;
  logic is_alu;

  assign is_hlt = (opcode == OP_HLT);
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        // HLT parks the sequencer on OP_ADDR; phase does not advance.
        if (phase_q == P_OP_ADDR && is_hlt) begin
          state_d = HALTED;
        end else begin
          phase_d = phase_q + 3'd1;
          if (phase_q == P_STORE) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      HALTED: begin
        if (go) begin
          state_d = RUN;
          phase_d = P_INST_ADDR;
        end
      end
      default: begin
        state_d = RUN;
        phase_d = P_INST_ADDR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      phase_q <= P_INST_ADDR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  // Fetch phases never look at opcode, so an unloaded IR cannot leak X.
  always_comb begin
    sel     = 1'b0;
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    inc_pc  = 1'b0;
    load_pc = 1'b0;
    load_ac = 1'b0;
    mem_wr  = 1'b0;
    data_e  = 1'b0;
    halt    = 1'b0;
    if (state_q == HALTED) begin
      halt = 1'b1;
    end else begin
      unique case (phase_q)
        P_INST_ADDR: begin
          sel = 1'b1;
        end
        P_INST_FETCH: begin
          sel    = 1'b1;
          mem_rd = 1'b1;
        end
        P_INST_LOAD, P_IDLE: begin
          sel     = 1'b1;
          mem_rd  = 1'b1;
          load_ir = 1'b1;
        end
        P_OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = is_hlt;
        end
        P_OP_FETCH: begin
          mem_rd = is_alu;
        end
        P_ALU_OP: begin
          mem_rd  = is_alu;
          inc_pc  = (opcode == OP_SKZ) && zero;
          load_pc = (opcode == OP_JMP);
          data_e  = (opcode == OP_STO);
        end
        P_STORE: begin
          mem_rd  = is_alu;
          load_ac = is_alu;
          load_pc = (opcode == OP_JMP);
          mem_wr  = (opcode == OP_STO);
          data_e  = (opcode == OP_STO);
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  assign phase     = phase_q;
  assign instr_cnt = cnt_q;

endmodule
